// File: rtl/soc_gpio_pio_ext_pkg.sv
// Shared definitions for the parametrised GPIO port: bus width, register offsets and edge modes.
package soc_gpio_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_DIR     = 3'd1;
  localparam logic [2:0] REG_IRQMASK = 3'd2;
  localparam logic [2:0] REG_EDGECAP = 3'd3;
  localparam logic [2:0] REG_OUTSET  = 3'd4;
  localparam logic [2:0] REG_OUTCLR  = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/soc_gpio_pio_ext_if.sv
// Avalon-MM slave bus bundle between the Nios II data master and the GPIO port.
interface soc_gpio_pio_ext_if;
  import soc_gpio_pkg::*;

  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/soc_gpio_pio_ext_sync_edge.sv
// Per-bit input synchroniser chain, previous-value register and edge detector for the GPIO pins.
module gpio_sync_edge
  import soc_gpio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int EDGE_TYPE   = EDGE_RISING,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] prev_r;

  // Synchroniser shift chain; prev follows in_sync every cycle regardless of direction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {WIDTH{1'b0}};
      end
      prev_r <= {WIDTH{1'b0}};
    end else begin
      sync_r[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign in_sync = sync_r[SYNC_STAGES-1];

  // Edge polarity selection fixed at elaboration.
  always_comb begin
    edge_det = {WIDTH{1'b0}};
    case (EDGE_TYPE)
      EDGE_RISING:  edge_det = in_sync & ~prev_r;
      EDGE_FALLING: edge_det = ~in_sync & prev_r;
      EDGE_ANY:     edge_det = in_sync ^ prev_r;
      default:      edge_det = in_sync & ~prev_r;
    endcase
  end

endmodule

// File: rtl/soc_gpio_pio_ext.sv
// Avalon-MM GPIO port: per-bit direction, set/clear writes, synchronised inputs,
// write-1-to-clear edge capture and a masked, registered level interrupt.
module soc_gpio_pio_ext
  import soc_gpio_pkg::*;
#(
  parameter int                WIDTH       = 16,
  parameter logic [DATA_W-1:0] RESET_VALUE = 32'h0000_0000,
  parameter logic [DATA_W-1:0] DIR_RESET   = 32'h0000_0000,
  parameter int                EDGE_TYPE   = EDGE_RISING,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  soc_gpio_pio_ext_if.slave   bus,
  input  logic [WIDTH-1:0]    in_port,
  output logic [WIDTH-1:0]    out_port,
  output logic [WIDTH-1:0]    oe,
  output logic                irq
);

  // Edge capture stays off until the synchroniser has flushed the pin state seen at reset.
  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] irqmask_r;
  logic [WIDTH-1:0] edgecap_r;
  logic             irq_r;
  logic [2:0]       arm_cnt_r;

  logic             wr_s;
  logic             armed_s;
  logic [WIDTH-1:0] wd_s;
  logic [WIDTH-1:0] in_sync_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] capture_s;
  logic [WIDTH-1:0] clr_s;
  logic             unused_wd_s;

  gpio_sync_edge #(
    .WIDTH      (WIDTH),
    .EDGE_TYPE  (EDGE_TYPE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .in_sync (in_sync_s),
    .edge_det(edge_s)
  );

  assign wr_s        = bus.chipselect & ~bus.write_n;
  assign wd_s        = bus.writedata[WIDTH-1:0];
  assign unused_wd_s = ^bus.writedata;
  assign armed_s     = (arm_cnt_r == ARM_DONE);

  // Capture and clear vectors; a new edge overrides a same-cycle clear of that bit.
  always_comb begin
    capture_s = {WIDTH{1'b0}};
    clr_s     = {WIDTH{1'b0}};
    if (armed_s) begin
      capture_s = edge_s & ~dir_r;
    end else begin
      capture_s = {WIDTH{1'b0}};
    end
    if (wr_s && (bus.address == REG_EDGECAP)) begin
      clr_s = wd_s;
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
  end

  // Register file, arm counter and interrupt flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= RESET_VALUE[WIDTH-1:0];
      dir_r      <= DIR_RESET[WIDTH-1:0];
      irqmask_r  <= {WIDTH{1'b0}};
      edgecap_r  <= {WIDTH{1'b0}};
      irq_r      <= 1'b0;
      arm_cnt_r  <= 3'd0;
    end else begin
      if (!armed_s) begin
        arm_cnt_r <= arm_cnt_r + 3'd1;
      end
      edgecap_r <= (edgecap_r & ~clr_s) | capture_s;
      irq_r     <= |(edgecap_r & irqmask_r);
      if (wr_s) begin
        case (bus.address)
          REG_DATA:    data_out_r <= wd_s;
          REG_DIR:     dir_r      <= wd_s;
          REG_IRQMASK: irqmask_r  <= wd_s;
          REG_OUTSET:  data_out_r <= data_out_r | wd_s;
          REG_OUTCLR:  data_out_r <= data_out_r & ~wd_s;
          default:     ;
        endcase
      end
    end
  end

  // Zero-wait-state read mux; unused upper bits and write-only/reserved offsets read zero.
  always_comb begin
    bus.readdata = {DATA_W{1'b0}};
    case (bus.address)
      REG_DATA:    bus.readdata = DATA_W'((dir_r & data_out_r) | (~dir_r & in_sync_s));
      REG_DIR:     bus.readdata = DATA_W'(dir_r);
      REG_IRQMASK: bus.readdata = DATA_W'(irqmask_r);
      REG_EDGECAP: bus.readdata = DATA_W'(edgecap_r);
      default:     bus.readdata = {DATA_W{1'b0}};
    endcase
  end

  assign out_port = data_out_r;
  assign oe       = dir_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_soc_gpio_pio_ext.sv
// Directed bench for soc_gpio_pio_ext: a rising-edge instance (A) and an any-edge instance (B).
module tb_soc_gpio_pio_ext;
  import soc_gpio_pkg::*;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [15:0] exp_out;
    logic [15:0] exp_oe;
    logic [2:0]  rd_addr;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 9;

  logic        clk;
  logic        reset_n;
  logic [15:0] in_a, out_a, oe_a;
  logic [15:0] in_b, out_b, oe_b;
  logic        irq_a, irq_b;
  logic [31:0] rd_val;
  int          checks = 0;
  int          failures = 0;
  vec_t        vecs [NV];

  soc_gpio_pio_ext_if bus_a ();
  soc_gpio_pio_ext_if bus_b ();

  soc_gpio_pio_ext #(
    .WIDTH(16), .RESET_VALUE(32'h0000_00A5), .DIR_RESET(32'h0000_0000),
    .EDGE_TYPE(EDGE_RISING), .SYNC_STAGES(2)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a),
    .in_port(in_a), .out_port(out_a), .oe(oe_a), .irq(irq_a)
  );

  soc_gpio_pio_ext #(
    .WIDTH(16), .RESET_VALUE(32'h0000_0000), .DIR_RESET(32'h0000_0000),
    .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(2)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b),
    .in_port(in_b), .out_port(out_b), .oe(oe_b), .irq(irq_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input int inst, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    if (inst == 0) begin
      bus_a.address = a; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    end else begin
      bus_b.address = a; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
    end
    @(negedge clk);
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
  endtask

  task automatic rd(input int inst, input logic [2:0] a, output logic [31:0] d);
    if (inst == 0) begin
      bus_a.address = a; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b1;
    end else begin
      bus_b.address = a; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b1;
    end
    #1;
    d = (inst == 0) ? bus_a.readdata : bus_b.readdata;
    bus_a.chipselect = 1'b0;
    bus_b.chipselect = 1'b0;
  endtask

  initial begin
    vecs[0] = '{REG_DIR,     32'h0000_00FF, 16'h00A5, 16'h00FF, REG_DIR,     32'h0000_00FF};
    vecs[1] = '{REG_DATA,    32'h0000_1234, 16'h1234, 16'h00FF, REG_DATA,    32'h0000_FF34};
    vecs[2] = '{REG_OUTSET,  32'h0000_0F00, 16'h1F34, 16'h00FF, REG_OUTSET,  32'h0000_0000};
    vecs[3] = '{REG_OUTCLR,  32'h0000_0004, 16'h1F30, 16'h00FF, REG_DATA,    32'h0000_FF30};
    vecs[4] = '{REG_IRQMASK, 32'h0000_0001, 16'h1F30, 16'h00FF, REG_IRQMASK, 32'h0000_0001};
    vecs[5] = '{REG_DATA,    32'hFFFF_1234, 16'h1234, 16'h00FF, REG_DATA,    32'h0000_FF34};
    vecs[6] = '{3'd6,        32'hFFFF_FFFF, 16'h1234, 16'h00FF, 3'd6,        32'h0000_0000};
    vecs[7] = '{3'd7,        32'hFFFF_FFFF, 16'h1234, 16'h00FF, 3'd7,        32'h0000_0000};
    vecs[8] = '{REG_DIR,     32'hFFFF_0200, 16'h1234, 16'h0200, REG_DIR,     32'h0000_0200};

    bus_a.address = 3'd0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = 32'h0;
    bus_b.address = 3'd0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = 32'h0;
    in_a = 16'hFFFF;
    in_b = 16'h0000;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;

    // Reset state with pins already high.
    repeat (3) @(negedge clk);
    check("rst_out", {16'h0, out_a}, 32'h0000_00A5);
    check("rst_oe", {16'h0, oe_a}, 32'h0);
    check("rst_irq", {31'h0, irq_a}, 32'h0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    rd(0, REG_EDGECAP, rd_val);
    check("arm_edgecap", rd_val, 32'h0);
    check("arm_irq", {31'h0, irq_a}, 32'h0);

    // Register map vectors on instance A.
    for (int i = 0; i < NV; i++) begin
      wr(0, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_out", i), {16'h0, out_a}, {16'h0, vecs[i].exp_out});
      check($sformatf("vec%0d_oe", i), {16'h0, oe_a}, {16'h0, vecs[i].exp_oe});
      rd(0, vecs[i].rd_addr, rd_val);
      check($sformatf("vec%0d_rd", i), rd_val, vecs[i].exp_rd);
    end

    // Falling edges are ignored in rising mode.
    @(negedge clk); in_a = 16'h0000;
    repeat (5) @(negedge clk);
    rd(0, REG_EDGECAP, rd_val);
    check("fall_ignored", rd_val, 32'h0);

    // Rising edge on bit 0: capture at k+2, irq at k+3, W1C drops irq one cycle later.
    @(negedge clk); in_a[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rd(0, REG_EDGECAP, rd_val);
    check("lat_k1_cap", rd_val, 32'h0);
    @(posedge clk); #1;
    rd(0, REG_EDGECAP, rd_val);
    check("lat_k2_cap", rd_val, 32'h1);
    check("lat_k2_irq", {31'h0, irq_a}, 32'h0);
    @(posedge clk); #1;
    check("lat_k3_irq", {31'h0, irq_a}, 32'h1);
    wr(0, REG_EDGECAP, 32'h0000_0001);
    check("w1c_irq_hold", {31'h0, irq_a}, 32'h1);
    rd(0, REG_EDGECAP, rd_val);
    check("w1c_cap", rd_val, 32'h0);
    @(posedge clk); #1;
    check("w1c_irq_drop", {31'h0, irq_a}, 32'h0);

    // Clear on bit 3 lands in the same cycle as its capture: edge wins.
    @(negedge clk); in_a[3] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wr(0, REG_EDGECAP, 32'h0000_0008);
    rd(0, REG_EDGECAP, rd_val);
    check("clr_vs_edge", rd_val, 32'h8);
    check("mask_filter_irq", {31'h0, irq_a}, 32'h0);
    wr(0, REG_IRQMASK, 32'h0000_0008);
    check("mask_irq_pre", {31'h0, irq_a}, 32'h0);
    @(posedge clk); #1;
    check("mask_irq_post", {31'h0, irq_a}, 32'h1);
    wr(0, REG_EDGECAP, 32'h0000_0008);
    @(posedge clk); #1;
    check("mask_irq_clr", {31'h0, irq_a}, 32'h0);

    // Any-edge instance: 3-cycle pulses on input bit 5 and output bit 9.
    wr(1, REG_DIR, 32'h0000_0200);
    check("b_oe", {16'h0, oe_b}, 32'h0000_0200);
    @(negedge clk); in_b[5] = 1'b1; in_b[9] = 1'b1;
    repeat (3) @(negedge clk);
    in_b = 16'h0000;
    repeat (5) @(negedge clk);
    rd(1, REG_EDGECAP, rd_val);
    check("any_pulse", rd_val, 32'h0000_0020);
    wr(1, REG_EDGECAP, 32'h0000_FFFF);
    @(negedge clk); in_b[5] = 1'b1;
    repeat (5) @(negedge clk);
    wr(1, REG_EDGECAP, 32'h0000_0020);
    rd(1, REG_EDGECAP, rd_val);
    check("any_clr", rd_val, 32'h0);
    @(negedge clk); in_b[5] = 1'b0;
    repeat (5) @(negedge clk);
    rd(1, REG_EDGECAP, rd_val);
    check("any_fall", rd_val, 32'h0000_0020);
    wr(1, REG_EDGECAP, 32'h0000_0020);
    @(negedge clk); in_b[9] = 1'b1;
    repeat (5) @(negedge clk);
    wr(1, REG_DIR, 32'h0000_0000);
    repeat (5) @(negedge clk);
    rd(1, REG_EDGECAP, rd_val);
    check("dir_switch_no_edge", rd_val, 32'h0);
    @(negedge clk); in_b[9] = 1'b0;
    repeat (5) @(negedge clk);
    rd(1, REG_EDGECAP, rd_val);
    check("dir_input_fall", rd_val, 32'h0000_0200);

    // Simultaneous edges on A, then reset in the middle of it.
    @(negedge clk); in_a = 16'h0000;
    repeat (4) @(negedge clk);
    in_a = 16'h0009;
    repeat (5) @(negedge clk);
    rd(0, REG_EDGECAP, rd_val);
    check("multi_edge", rd_val, 32'h0000_0009);
    check("multi_irq", {31'h0, irq_a}, 32'h1);
    @(negedge clk); reset_n = 1'b0;
    #1;
    check("mid_rst_out", {16'h0, out_a}, 32'h0000_00A5);
    check("mid_rst_oe", {16'h0, oe_a}, 32'h0);
    check("mid_rst_irq", {31'h0, irq_a}, 32'h0);
    rd(0, REG_EDGECAP, rd_val);
    check("mid_rst_cap", rd_val, 32'h0);
    rd(0, REG_IRQMASK, rd_val);
    check("mid_rst_mask", rd_val, 32'h0);
    rd(0, REG_DATA, rd_val);
    check("mid_rst_data", rd_val, 32'h0);
    rd(1, REG_EDGECAP, rd_val);
    check("mid_rst_b_cap", rd_val, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    rd(0, REG_EDGECAP, rd_val);
    check("rearm_cap", rd_val, 32'h0);
    in_a[0] = 1'b0;
    repeat (4) @(negedge clk);
    in_a[0] = 1'b1;
    repeat (5) @(negedge clk);
    rd(0, REG_EDGECAP, rd_val);
    check("post_arm_cap", rd_val, 32'h1);
    check("b_irq_idle", {31'h0, irq_b}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
